// File: rtl/inert_pkg.sv
// rtl/inert_pkg.sv - shared types and constants for the inertial burst sequencer
package inert_pkg;

  typedef enum logic [2:0] {PWRUP, INIT, IDLE, RDLO, RDHI} state_t;

  localparam logic [7:0] RD_PAD     = 8'h00;
  localparam int         PWR_W_FAST = 9;
  localparam int         PWR_W_SLOW = 16;

  // Register address of channel ch, low (hi=0) or high (hi=1) byte; wraps mod 256
  function automatic logic [7:0] rd_addr(input logic [7:0] base, input logic [2:0] ch,
                                         input logic hi);
    return base + {4'b0000, ch, 1'b0} + {7'b0000000, hi};
  endfunction

endpackage

// File: rtl/inert_burst_seq.sv
// rtl/inert_burst_seq.sv - SPI register sequencer: power-up init writes, INT-triggered burst reads
module inert_burst_seq
  import inert_pkg::*;
#(
  parameter int                      NUM_CH    = 5,
  parameter int                      NUM_INIT  = 4,
  parameter logic [NUM_INIT*16-1:0]  INIT_CMDS = {16'h0D02, 16'h1062, 16'h1162, 16'h1460},
  parameter logic [7:0]              RD_BASE   = 8'hA2,
  parameter bit                      FAST_SIM  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   INT,
  input  logic                   rd_en,
  input  logic                   clr_ovr,
  input  logic                   done,
  input  logic [15:0]            rd_data,
  output logic                   wrt,
  output logic [15:0]            cmd,
  output logic                   init_done,
  output logic                   vld,
  output logic                   ovr,
  output logic [NUM_CH*16-1:0]   data
);

  localparam int PWR_W = FAST_SIM ? PWR_W_FAST : PWR_W_SLOW;

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("inert_burst_seq: NUM_CH must be 1..8");
  end
  if (NUM_INIT < 1 || NUM_INIT > 8) begin : g_bad_num_init
    $error("inert_burst_seq: NUM_INIT must be 1..8");
  end

  state_t            state, state_n;
  logic [PWR_W-1:0]  timer, timer_n;
  logic [2:0]        idx, idx_n;
  logic [2:0]        ch, ch_n;
  logic              wrt_n, init_done_n, vld_n, ovr_n;
  logic [15:0]       cmd_n;
  logic              int_m, int_s, int_s_d, int_rise;
  logic              lo_we, hi_we, pub;
  logic [15:0]       shadow [NUM_CH];
  logic [15:0]       init_tbl [8];
  logic              unused_rd_hi;

  assign unused_rd_hi = ^rd_data[15:8];
  assign int_rise     = int_s & ~int_s_d;

  // Unpack the init table so entry 0 (issued first) comes from the MS 16 bits
  for (genvar g = 0; g < 8; g++) begin : g_init_tbl
    if (g < NUM_INIT) begin : g_used
      assign init_tbl[g] = INIT_CMDS[(NUM_INIT-1-g)*16 +: 16];
    end else begin : g_pad
      assign init_tbl[g] = 16'h0000;
    end
  end

  // Bring the asynchronous INT into the clock domain and keep one delayed copy for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_m   <= 1'b0;
      int_s   <= 1'b0;
      int_s_d <= 1'b0;
    end else begin
      int_m   <= INT;
      int_s   <= int_m;
      int_s_d <= int_s;
    end
  end

  // Next-state, command and strobe decode; done is only acted on while a transfer is outstanding
  always_comb begin
    state_n     = state;
    timer_n     = timer;
    idx_n       = idx;
    ch_n        = ch;
    wrt_n       = 1'b0;
    cmd_n       = cmd;
    init_done_n = init_done;
    vld_n       = 1'b0;
    lo_we       = 1'b0;
    hi_we       = 1'b0;
    pub         = 1'b0;
    case (state)
      PWRUP: begin
        timer_n = timer + 1'b1;
        if (&timer) begin
          wrt_n   = 1'b1;
          cmd_n   = init_tbl[3'd0];
          idx_n   = 3'd0;
          state_n = INIT;
        end
      end
      INIT: begin
        if (done) begin
          if (idx == 3'(NUM_INIT - 1)) begin
            init_done_n = 1'b1;
            state_n     = IDLE;
          end else begin
            idx_n = idx + 3'd1;
            wrt_n = 1'b1;
            cmd_n = init_tbl[idx + 3'd1];
          end
        end
      end
      IDLE: begin
        if (int_s && rd_en) begin
          ch_n    = 3'd0;
          wrt_n   = 1'b1;
          cmd_n   = {rd_addr(RD_BASE, 3'd0, 1'b0), RD_PAD};
          state_n = RDLO;
        end
      end
      RDLO: begin
        if (done) begin
          lo_we   = 1'b1;
          wrt_n   = 1'b1;
          cmd_n   = {rd_addr(RD_BASE, ch, 1'b1), RD_PAD};
          state_n = RDHI;
        end
      end
      RDHI: begin
        if (done) begin
          hi_we = 1'b1;
          if (ch < 3'(NUM_CH - 1)) begin
            ch_n    = ch + 3'd1;
            wrt_n   = 1'b1;
            cmd_n   = {rd_addr(RD_BASE, ch + 3'd1, 1'b0), RD_PAD};
            state_n = RDLO;
          end else begin
            pub     = 1'b1;
            vld_n   = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = PWRUP;
    endcase
    // A new INT edge during a burst beats a same-cycle clear
    if (int_rise && (state == RDLO || state == RDHI)) begin
      ovr_n = 1'b1;
    end else if (clr_ovr) begin
      ovr_n = 1'b0;
    end else begin
      ovr_n = ovr;
    end
  end

  // Control state and registered SPI-side outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= PWRUP;
      timer     <= '0;
      idx       <= 3'd0;
      ch        <= 3'd0;
      wrt       <= 1'b0;
      cmd       <= 16'h0000;
      init_done <= 1'b0;
      vld       <= 1'b0;
      ovr       <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      idx       <= idx_n;
      ch        <= ch_n;
      wrt       <= wrt_n;
      cmd       <= cmd_n;
      init_done <= init_done_n;
      vld       <= vld_n;
      ovr       <= ovr_n;
    end
  end

  // Bytewise shadow capture; publish all channels at once, merging the final high byte directly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= 16'h0000;
      data <= '0;
    end else begin
      if (lo_we) shadow[ch][7:0]  <= rd_data[7:0];
      if (hi_we) shadow[ch][15:8] <= rd_data[7:0];
      if (pub) begin
        for (int i = 0; i < NUM_CH; i++) begin
          data[16*i +: 16] <= (3'(i) == ch) ? {rd_data[7:0], shadow[i][7:0]} : shadow[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_inert_burst_seq.sv
// tb/tb_inert_burst_seq.sv - randomized scoreboard bench for inert_burst_seq
module tb_inert_burst_seq;

  localparam int          NUM_CH   = 5;
  localparam int          NUM_INIT = 4;
  localparam logic [7:0]  RD_BASE  = 8'hA2;
  localparam int          DW       = NUM_CH * 16;

  logic            clk, rst, int_in, rd_en, clr_ovr, done, done_spi, done_spur;
  logic [15:0]     rd_data;
  logic            wrt, init_done, vld, ovr;
  logic [15:0]     cmd;
  logic [DW-1:0]   data;

  assign done = done_spi | done_spur;

  inert_burst_seq #(
    .NUM_CH(NUM_CH), .NUM_INIT(NUM_INIT), .INIT_CMDS(64'h0D02_1062_1162_1460),
    .RD_BASE(RD_BASE), .FAST_SIM(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .INT(int_in), .rd_en(rd_en), .clr_ovr(clr_ovr), .done(done),
    .rd_data(rd_data), .wrt(wrt), .cmd(cmd), .init_done(init_done), .vld(vld), .ovr(ovr),
    .data(data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Reference model state
  logic [15:0]    init_tbl [NUM_INIT] = '{16'h0D02, 16'h1062, 16'h1162, 16'h1460};
  logic [15:0]    exp_cmd [$];
  logic [DW-1:0]  exp_data [$];
  logic [DW-1:0]  last_pub;
  logic [7:0]     rd_bytes [2*NUM_CH];
  bit             init_seen, in_burst, first_wrt;
  int             init_cnt, done_cyc, init_done_cyc, rd_done_cyc, burst_pos;
  int             wrt_count, pub_count, lat_fix;
  int             checks, passes;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic reset_model();
    exp_cmd.delete();
    exp_data.delete();
    last_pub  = '0;
    init_seen = 1'b0;
    init_cnt  = 0;
    in_burst  = 1'b0;
    burst_pos = 0;
    first_wrt = 1'b1;
  endtask

  // SPI slave model: answer each wrt after a latency with a random byte
  initial begin : spi_model
    logic [15:0] c;
    logic [7:0]  b;
    logic [DW-1:0] v;
    int lat, ix;
    bit ab;
    done_spi = 1'b0;
    rd_data  = 16'h0000;
    forever begin
      @(negedge clk);
      while (wrt && !rst) begin
        c   = cmd;
        lat = !init_seen ? 40 : (lat_fix != 0 ? lat_fix : int'($urandom_range(3, 12)));
        ab  = 1'b0;
        for (int k = 0; k < lat; k++) begin
          @(negedge clk);
          if (rst) begin ab = 1'b1; break; end
        end
        if (!ab) begin
          b        = 8'($urandom);
          rd_data  = {8'($urandom), b};
          done_spi = 1'b1;
          done_cyc = cyc;
          if (!init_seen) begin
            init_cnt++;
            if (init_cnt == NUM_INIT) begin
              init_seen     = 1'b1;
              init_done_cyc = cyc;
            end
          end else begin
            ix = int'(c[15:8] - RD_BASE);
            if (ix < 2*NUM_CH) rd_bytes[ix] = b;
            if (ix == 2*NUM_CH - 1) begin
              for (int i = 0; i < NUM_CH; i++) v[16*i +: 16] = {rd_bytes[2*i+1], rd_bytes[2*i]};
              exp_data.push_back(v);
              rd_done_cyc = cyc;
            end
          end
          @(negedge clk);
          done_spi = 1'b0;
        end
      end
    end
  end

  // Monitor: compare every wrt/cmd and every publish against the model queues
  initial begin : monitor
    bit vld_prev, id_prev, refilled;
    logic [DW-1:0] e;
    vld_prev = 1'b0;
    id_prev  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        vld_prev = 1'b0;
        id_prev  = 1'b0;
      end else begin
        if (wrt) begin
          wrt_count++;
          refilled = 1'b0;
          if (exp_cmd.size() == 0 && init_seen) begin
            for (int i = 0; i < 2*NUM_CH; i++) exp_cmd.push_back({RD_BASE + 8'(i), 8'h00});
            in_burst  = 1'b1;
            burst_pos = 0;
            refilled  = 1'b1;
          end
          if (first_wrt) begin
            check("pwrup_wrt_cycle", cyc, 512);
            first_wrt = 1'b0;
          end else if (!refilled) begin
            check("wrt_latency", cyc, done_cyc + 1);
          end
          check("wrt_expected", exp_cmd.size() != 0, 1);
          if (exp_cmd.size() != 0) check("cmd", cmd, exp_cmd.pop_front());
          burst_pos++;
        end
        if (vld) begin
          pub_count++;
          check("vld_pulse_width", vld_prev, 0);
          check("vld_latency", cyc, rd_done_cyc + 1);
          check("vld_expected", exp_data.size() != 0, 1);
          if (exp_data.size() != 0) begin
            e = exp_data.pop_front();
            check("data", data, e);
            last_pub = e;
          end
          in_burst = 1'b0;
        end else begin
          check("data_hold", data, last_pub);
        end
        if (init_done && !id_prev) check("init_done_latency", cyc, init_done_cyc + 1);
        vld_prev = vld;
        id_prev  = init_done;
      end
    end
  end

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    foreach (init_tbl[i]) exp_cmd.push_back(init_tbl[i]);
  endtask

  task automatic wait_init();
    int n = 0;
    while (!init_done && n < 3000) begin @(negedge clk); n++; end
    check("init_done_reached", init_done, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    repeat (5) @(negedge clk);
    while ((in_burst || exp_cmd.size() != 0 || exp_data.size() != 0) && n < 5000) begin
      @(negedge clk); n++;
    end
    check("idle_reached", in_burst, 0);
  endtask

  task automatic wait_burst();
    int n = 0;
    while (!in_burst && n < 200) begin @(negedge clk); n++; end
    check("burst_started", in_burst, 1);
  endtask

  task automatic wait_pub(input int target);
    int n = 0;
    while (pub_count < target && n < 5000) begin @(negedge clk); n++; end
    check("burst_count_reached", pub_count >= target, 1);
  endtask

  initial begin : stimulus
    int w, p;
    rst = 1'b1; int_in = 1'b0; rd_en = 1'b1; clr_ovr = 1'b0; done_spur = 1'b0;
    lat_fix = 0; checks = 0; passes = 0; wrt_count = 0; pub_count = 0;
    reset_model();
    repeat (3) @(negedge clk);
    check("rst_wrt", wrt, 0);
    check("rst_cmd", cmd, 0);
    check("rst_init_done", init_done, 0);
    check("rst_vld", vld, 0);
    check("rst_ovr", ovr, 0);
    check("rst_data", data, 0);
    release_reset();
    wait_init();

    // INT held high: back-to-back bursts
    int_in = 1'b1;
    wait_pub(pub_count + 3);

    // Random INT / rd_en activity
    for (int i = 0; i < 30; i++) begin
      int_in = 1'($urandom_range(0, 1));
      rd_en  = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(1, 60)) @(negedge clk);
    end
    int_in = 1'b0;
    rd_en  = 1'b1;
    wait_idle();

    // Overrun: INT re-rises mid-burst
    clr_ovr = 1'b1;
    @(negedge clk) clr_ovr = 1'b0;
    check("ovr_clear", ovr, 0);
    lat_fix = 30;
    int_in = 1'b1;
    wait_burst();
    repeat (10) @(negedge clk);
    int_in = 1'b0;
    repeat (4) @(negedge clk);
    int_in = 1'b1;
    repeat (6) @(negedge clk);
    int_in = 1'b0;
    wait_idle();
    check("ovr_set_midburst", ovr, 1);
    clr_ovr = 1'b1;
    @(negedge clk) clr_ovr = 1'b0;
    check("ovr_clear2", ovr, 0);

    // Overrun set coincides with clr_ovr: set must win
    int_in = 1'b1;
    wait_burst();
    int_in = 1'b0;
    repeat (10) @(negedge clk);
    clr_ovr = 1'b1;
    int_in  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    clr_ovr = 1'b0;
    check("ovr_set_wins", ovr, 1);
    int_in = 1'b0;
    wait_idle();
    lat_fix = 0;

    // rd_en gating and spurious done in IDLE
    rd_en  = 1'b0;
    int_in = 1'b1;
    wait_idle();
    w = wrt_count;
    repeat (30) @(negedge clk);
    check("no_wrt_rd_en_low", wrt_count, w);
    done_spur = 1'b1;
    @(negedge clk) done_spur = 1'b0;
    repeat (5) @(negedge clk);
    check("spurious_done_no_wrt", wrt_count, w);
    check("spurious_done_init_done", init_done, 1);
    p = pub_count;
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    check("rd_en_start_wrt", wrt, 1);
    repeat (3) @(negedge clk);
    rd_en  = 1'b0;
    int_in = 1'b0;
    wait_idle();
    check("burst_completes_rd_en_low", pub_count, p + 1);
    rd_en = 1'b1;

    // Reset during RDHI of channel 2
    lat_fix = 20;
    int_in  = 1'b1;
    begin
      int n = 0;
      while (!(in_burst && burst_pos == 6) && n < 2000) begin @(negedge clk); n++; end
      check("reached_rdhi_ch2", burst_pos, 6);
    end
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_wrt", wrt, 0);
    check("midrst_data", data, 0);
    check("midrst_init_done", init_done, 0);
    check("midrst_vld", vld, 0);
    reset_model();
    int_in  = 1'b0;
    lat_fix = 0;
    repeat (3) @(negedge clk);
    release_reset();
    wait_init();
    int_in = 1'b1;
    wait_pub(pub_count + 1);
    int_in = 1'b0;
    wait_idle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
